// File: rtl/sc_stream_decoder_pkg.sv
// Shared definitions for the stochastic stream decoder: FSM encoding and default width.
package sc_stream_decoder_pkg;

    localparam int NBITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/sc_ones_counter.sv
// Window counters: number of accepted stream bits and number of ones among them.
module sc_ones_counter
    import sc_stream_decoder_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [NBITS-1:0] ones,
    output logic [NBITS-1:0] bit_cnt
);

    logic [NBITS-1:0] ones_q, ones_d;
    logic [NBITS-1:0] bit_cnt_q, bit_cnt_d;

    // Counts never exceed the window length, so no saturation logic is needed.
    always_comb begin
        ones_d    = ones_q;
        bit_cnt_d = bit_cnt_q;
        if (clr) begin
            ones_d    = '0;
            bit_cnt_d = '0;
        end else if (en) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_in) begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, so no flop powers up into a visible X.
        if (rst) begin
            ones_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            ones_q    <= ones_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign ones    = ones_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic bit-stream decoder: counts ones over a window of L bits and reports the
// count as unipolar (ones) or bipolar (2*ones - L) through a valid/ready result port.
module sc_stream_decoder
    import sc_stream_decoder_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] win_len,
    input  logic             bipolar,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [NBITS-1:0] m_count,
    output logic [NBITS:0]   m_value,
    output logic [NBITS-1:0] m_len
);

    localparam logic [NBITS-1:0] LEN_MAX = '1;
    localparam logic [NBITS:0]   ONE_W   = 1;

    state_e           state_q, state_d;
    logic [NBITS-1:0] len_q, len_d;
    logic             bip_q, bip_d;
    logic [NBITS-1:0] m_count_q, m_count_d;
    logic [NBITS:0]   m_value_q, m_value_d;
    logic [NBITS-1:0] m_len_q, m_len_d;

    logic             cnt_clr;
    logic             xfer;
    logic             last_bit;
    logic [NBITS-1:0] ones;
    logic [NBITS-1:0] bit_cnt;
    logic [NBITS-1:0] ones_next;
    logic [NBITS:0]   uni_val;
    logic [NBITS:0]   bip_val;

    sc_ones_counter #(
        .NBITS(NBITS)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (xfer),
        .bit_in (s_bit),
        .ones   (ones),
        .bit_cnt(bit_cnt)
    );

    assign xfer      = (state_q == ST_ACCUM) && s_valid;
    assign last_bit  = xfer && (({1'b0, bit_cnt} + ONE_W) == {1'b0, len_q});
    // The final bit is folded in here so the result is ready the cycle DONE is entered.
    assign ones_next = ones + {{(NBITS-1){1'b0}}, s_bit};
    assign uni_val   = {1'b0, ones_next};
    // Modulo 2^(NBITS+1) subtraction yields the exact two's-complement result.
    assign bip_val   = {ones_next, 1'b0} - {1'b0, len_q};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        bip_d     = bip_q;
        m_count_d = m_count_q;
        m_value_d = m_value_q;
        m_len_d   = m_len_q;
        cnt_clr   = 1'b0;
        s_ready   = 1'b0;
        busy      = 1'b0;
        m_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = (win_len == '0) ? LEN_MAX : win_len;
                    bip_d   = bipolar;
                    cnt_clr = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (last_bit) begin
                    m_count_d = ones_next;
                    m_value_d = bip_q ? bip_val : uni_val;
                    m_len_d   = len_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            bip_q     <= 1'b0;
            m_count_q <= '0;
            m_value_q <= '0;
            m_len_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            bip_q     <= bip_d;
            m_count_q <= m_count_d;
            m_value_q <= m_value_d;
            m_len_q   <= m_len_d;
        end
    end

    assign m_count = m_count_q;
    assign m_value = m_value_q;
    assign m_len   = m_len_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder: directed windows plus randomized traffic,
// compared every cycle against a window-level reference model.
module tb_sc_stream_decoder;

    localparam int NBITS = 8;
    localparam int LMAX  = (1 << NBITS) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NBITS-1:0] win_len;
    logic             bipolar;
    logic             s_valid;
    logic             s_bit;
    logic             s_ready;
    logic             busy;
    logic             m_valid;
    logic             m_ready;
    logic [NBITS-1:0] m_count;
    logic [NBITS:0]   m_value;
    logic [NBITS-1:0] m_len;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    sc_stream_decoder #(
        .NBITS(NBITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .win_len(win_len),
        .bipolar(bipolar),
        .s_valid(s_valid),
        .s_bit  (s_bit),
        .s_ready(s_ready),
        .busy   (busy),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_count(m_count),
        .m_value(m_value),
        .m_len  (m_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window open / result pending, with plain integer counts.
    bit mdl_open, mdl_pend, mdl_bp;
    int mdl_n, mdl_k, mdl_l;
    int res_cnt, res_val, res_len;

    always @(posedge clk) begin
        if (rst) begin
            mdl_open = 0; mdl_pend = 0; mdl_bp = 0;
            mdl_n = 0; mdl_k = 0; mdl_l = 0;
            res_cnt = 0; res_val = 0; res_len = 0;
        end else if (mdl_open) begin
            if (s_valid) begin
                mdl_n++;
                mdl_k += int'(s_bit);
                if (mdl_n == mdl_l) begin
                    mdl_open = 0;
                    mdl_pend = 1;
                    res_cnt  = mdl_k;
                    res_val  = mdl_bp ? (2 * mdl_k - mdl_l) : mdl_k;
                    res_len  = mdl_l;
                end
            end
        end else if (mdl_pend) begin
            if (m_ready) mdl_pend = 0;
        end else if (start) begin
            mdl_l    = (win_len == 0) ? LMAX : int'(win_len);
            mdl_bp   = bipolar;
            mdl_n    = 0;
            mdl_k    = 0;
            mdl_open = 1;
        end
    end

    logic [NBITS:0] exp_val;
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_val = res_val[NBITS:0];
            check("s_ready", s_ready, mdl_open);
            check("busy",    busy,    mdl_open | mdl_pend);
            check("m_valid", m_valid, mdl_pend);
            check("m_count", m_count, res_cnt);
            check("m_value", m_value, exp_val);
            check("m_len",   m_len,   res_len);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_win(input int wl, input bit bp);
        start   = 1'b1;
        win_len = wl[NBITS-1:0];
        bipolar = bp;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input bit b);
        s_valid = 1'b1;
        s_bit   = b;
        tick();
        s_valid = 1'b0;
        s_bit   = 1'b0;
    endtask

    task automatic wait_mv(input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_m_valid", m_valid, 1);
    endtask

    logic [7:0] gap_pat;

    initial begin
        rst = 1'b1; start = 1'b0; win_len = '0; bipolar = 1'b0;
        s_valid = 1'b0; s_bit = 1'b0; m_ready = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_busy",    busy,    0);
        check("reset_m_count", m_count, 0);
        tick();

        // Full 255-bit unipolar window, 128 ones, result one cycle after the last bit.
        open_win(0, 0);
        for (int i = 0; i < LMAX; i++) send(i % 2 == 0);
        check("full_latency_m_valid", m_valid, 1);
        check("full_m_count", m_count, 128);
        check("full_m_value", m_value, 128);
        check("full_m_len",   m_len,   255);
        tick();
        check("full_m_valid_pulse", m_valid, 0);

        // Bipolar 16-bit windows.
        open_win(16, 1);
        for (int i = 0; i < 16; i++) send(i < 4);
        wait_mv(4);
        check("bip4_m_value", m_value, 9'h1F8);
        tick();
        open_win(16, 1);
        for (int i = 0; i < 16; i++) send(1'b1);
        wait_mv(4);
        check("bip16_m_value", m_value, 9'h010);
        tick();

        // Gapped stream with backpressure held in DONE.
        m_ready = 1'b0;
        gap_pat = 8'b1011_0010;
        open_win(8, 0);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b0;
            s_bit   = 1'b1;
            tick();
            send(gap_pat[i]);
        end
        for (int c = 0; c < 10; c++) begin
            s_valid = c[0];
            s_bit   = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check("gap_m_valid_held", m_valid, 1);
        check("gap_s_ready_done", s_ready, 0);
        check("gap_m_count",      m_count, 4);
        m_ready = 1'b1;
        tick();
        check("gap_release_busy", busy, 0);

        // Start ignored in ACCUM and in the DONE handshake cycle.
        open_win(5, 0);
        send(1'b1);
        send(1'b1);
        start = 1'b1; win_len = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1);
        check("ign_m_len",   m_len,   5);
        check("ign_m_count", m_count, 5);
        start = 1'b1; win_len = 8'd4;
        tick();
        start = 1'b0;
        check("ign_done_busy", busy, 0);
        tick();
        check("ign_no_restart", s_ready, 0);
        open_win(4, 0);
        for (int i = 0; i < 4; i++) send(1'b0);
        check("fresh_m_count", m_count, 0);
        check("fresh_m_len",   m_len,   4);
        tick();

        // Reset after 50 of 255 bits, then a clean 10-bit window.
        open_win(0, 0);
        for (int i = 0; i < 50; i++) send(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_len",   m_len,   0);
        open_win(10, 0);
        for (int i = 0; i < 10; i++) send(1'b1);
        check("post_rst_m_count", m_count, 10);
        tick();

        // Length-1 windows of a zero bit.
        open_win(1, 0);
        send(1'b0);
        check("len1_m_count", m_count, 0);
        check("len1_m_value", m_value, 0);
        tick();
        open_win(1, 1);
        send(1'b0);
        check("len1_bip_m_value", m_value, 9'h1FF);
        tick();

        // Randomized traffic, including stray starts, gaps, backpressure and rare resets.
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 599) == 0);
            start   = ($urandom_range(0, 5) == 0);
            win_len = ($urandom_range(0, 15) == 0) ? '0 : NBITS'($urandom_range(1, 24));
            bipolar = 1'($urandom);
            s_valid = ($urandom_range(0, 3) != 0);
            s_bit   = 1'($urandom);
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 Parameter NBITS, default 8, binary width of the stream window length and the ones count.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to open a decode window.
REQ-005 win_len  input  NBITS  stream window length in bits; 0 encodes 2^NBITS-1.
REQ-006 bipolar  input  1  output coding select: 0 unipolar, 1 bipolar.
REQ-007 s_valid  input  1  stochastic stream bit valid.
REQ-008 s_bit  input  1  stochastic stream bit, e.g. the MAC adder stream.
REQ-009 s_ready  output  1  decoder accepts a stream bit this cycle.
REQ-010 busy  output  1  window open or result pending.
REQ-011 m_valid  output  1  decoded result valid.
REQ-012 m_ready  input  1  downstream accepts the result.
REQ-013 m_count  output  NBITS  number of ones counted in the window.
REQ-014 m_value  output  NBITS+1  decoded value, two's complement; see REQ-024.
REQ-015 m_len  output  NBITS  effective window length used, after the 0 mapping.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-017 IDLE: s_ready=0, m_valid=0 and busy=0.
- start=1 latches the effective length L (win_len, or 2^NBITS-1 when win_len=0) and latches bipolar.
- start also clears the ones counter and the bit counter, then moves to ACCUM.
REQ-018 ACCUM: s_ready=1 and busy=1.
- A bit transfers when s_valid and s_ready are both 1.
- On each transfer, bit_cnt increments and ones increments when s_bit=1.
- Cycles with s_valid=0 change nothing.
REQ-019 The transfer that makes bit_cnt reach L moves the FSM to DONE on the next edge, with that bit included in the count.
REQ-020 start asserted in ACCUM or DONE SHALL be ignored.
REQ-021 DONE: s_ready=0, m_valid=1 and busy=1.
- m_count, m_value and m_len stay stable until the m_valid and m_ready handshake completes.
- On handshake the FSM returns to IDLE.
REQ-022 The FSM SHALL NOT pass directly from DONE to ACCUM.
- start in the same cycle as the DONE handshake is ignored.
- The next window needs start while in IDLE.
REQ-023 Latency: m_valid rises exactly one cycle after the L-th accepted bit; with s_valid held high this is L+1 cycles after start.
REQ-024 Output coding:
- Unipolar: m_value = zero-extended ones.
- Bipolar: m_value = 2*ones - L, computed in NBITS+1 bits signed, range -(2^NBITS-1)..+(2^NBITS-1).
REQ-025 Counters are NBITS wide and SHALL NOT wrap, because bit_cnt is bounded by L ≤ 2^NBITS-1.
REQ-026 Outputs SHALL be registered; no combinational path from s_* to m_*.
REQ-027 m_count, m_value and m_len SHALL hold their last value outside DONE.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE and clear ones, bit_cnt, L and the latched bipolar select.
- Also clears m_count, m_value and m_len to 0.
- Leaves s_ready=0, m_valid=0 and busy=0.
REQ-029 Reset mid-ACCUM or mid-DONE SHALL discard the partial or pending result with no handshake.
REQ-030 rst SHALL take priority over start and over all handshakes in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10) and the NBITS default.
REQ-032 The ones and bit counting SHALL be one sub-module, sc_ones_counter.
- Inputs: clr, en, bit.
- Outputs: ones, bit_cnt.
- sc_stream_decoder holds the FSM, length latch, coding arithmetic and output registers.

Verification
REQ-033 Full unipolar window:
- Stimulus: start with win_len=0, bipolar=0; 255 valid bits with exactly 128 ones; m_ready=1.
- Response: m_count=128, m_value=128, m_len=255; m_valid for one cycle, 256 cycles after start.
REQ-034 Bipolar short window:
- Stimulus: win_len=16, bipolar=1, stream of 4 ones.
- Response: m_value=-8 (9'h1F8); with 16 ones, m_value=+16.
REQ-035 Gapped stream and backpressure:
- Stimulus: win_len=8 with s_valid toggling every cycle; m_ready held low for 10 cycles in DONE.
- Response: only 8 accepted bits counted; s_ready=0 and outputs stable throughout DONE.
REQ-036 Ignored start:
- Stimulus: start pulses during ACCUM and in the DONE handshake cycle.
- Response: no restart; FSM goes to IDLE, and a later start in IDLE opens a fresh window with counters cleared.
REQ-037 Reset mid-window:
- Stimulus: rst after 50 of 255 bits.
- Response: next cycle IDLE with all outputs 0; a following window of 10 ones with win_len=10 yields m_count=10.
REQ-038 Edge lengths:
- Stimulus: win_len=1 with an all-zero stream.
- Response: m_count=0; in bipolar mode m_value=-1.
